ps2_key_decoder: RTL and testbench

//   Parametrised PS/2 keyboard front end, sitting between ps2_host_rxtx and game control logic.
//   - Enables the keyboard by sending 0xF4 and checking for the 0xFA ack, with retry and timeout.
//   - Decodes set-2 make, break (0xF0) and extended (0xE0) sequences for NUM_KEYS configurable keys.
//   - Per key: held level, press tick and release tick. Keys are independent, so multi-key rollover works.

---
 rtl/ps2_key_pkg.sv | 53 +++++
 rtl/ps2_key_repeat.sv | 49 ++++
 rtl/ps2_key_decoder.sv | 198 +++++++++++++++++++
 tb/tb_ps2_key_decoder.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_key_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ps2_key_pkg
// Brief    : Shared constants, state encodings and helpers for the PS/2 key
//            decoder (byte codes, init/decode FSM states, default key map).
// Revision : 1.0  initial release
// ============================================================================
package ps2_key_pkg;

  // Host command and keyboard response bytes
  localparam logic [7:0] PS2_CMD_ENABLE = 8'hF4;
  localparam logic [7:0] PS2_ACK        = 8'hFA;
  localparam logic [7:0] PS2_BREAK      = 8'hF0;
  localparam logic [7:0] PS2_EXT        = 8'hE0;
  localparam logic [7:0] PS2_BAT        = 8'hAA;
  localparam logic [7:0] PS2_ECHO       = 8'hEE;
  localparam logic [7:0] PS2_RESEND     = 8'hFE;
  localparam logic [7:0] PS2_PAUSE      = 8'hE1;

  // Default key map, key i at [9*i+8:9*i], bit 8 marks an E0-extended code.
  // key0 left=E0 6B, key1 right=E0 74, key2 rotate=E0 75, key3 down=E0 72,
  // key4 drop=29
  localparam logic [44:0] PS2_DEFAULT_KEY_CODES =
      {9'h029, 9'h172, 9'h175, 9'h174, 9'h16B};

  // State encodings
  localparam int INIT_STATE_W = 3;
  localparam int DEC_STATE_W  = 2;

  typedef enum logic [INIT_STATE_W-1:0] {
    INIT_IDLE     = 3'd0,
    INIT_SEND     = 3'd1,
    INIT_WAIT_TX  = 3'd2,
    INIT_WAIT_ACK = 3'd3,
    INIT_READY    = 3'd4,
    INIT_ERR      = 3'd5
  } init_state_e;

  typedef enum logic [DEC_STATE_W-1:0] {
    D_IDLE    = 2'd0,
    D_EXT     = 2'd1,
    D_BRK     = 2'd2,
    D_EXT_BRK = 2'd3
  } dec_state_e;

  // Keyboard status/response bytes that carry no key information
  function automatic logic ps2_is_status(input logic [7:0] b);
    return (b == PS2_ACK) || (b == PS2_BAT) || (b == PS2_ECHO) ||
           (b == PS2_RESEND) || (b == PS2_PAUSE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_key_repeat.sv
`default_nettype none
// ============================================================================
// Module   : ps2_key_repeat
// Brief    : Per-key typematic generator. Counts cycles while a key is held
//            and emits repeat ticks at REPEAT_DELAY, then every REPEAT_PERIOD.
//            Only built when PS2_KEY_REPEAT_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
`ifdef PS2_KEY_REPEAT_EN
module ps2_key_repeat #(
  parameter int REPEAT_DELAY  = 25_000_000,
  parameter int REPEAT_PERIOD = 5_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic held,
  input  logic make,
  output logic repeat_tick
);

  localparam logic [24:0] c_delay = 25'(REPEAT_DELAY);
  localparam logic [24:0] c_wrap  = 25'(REPEAT_DELAY + REPEAT_PERIOD);

  logic [24:0] cnt_q, cnt_d;

  // Counter restarts on make; after the first repeat it folds back so the
  // DELAY+PERIOD point recurs every PERIOD cycles. Saturates at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (make || !held) begin
      cnt_d = '0;
    end else if (cnt_q == c_wrap) begin
      cnt_d = c_delay + 25'd1;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + 25'd1;
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign repeat_tick = held && ((cnt_q == c_delay) || (cnt_q == c_wrap));

endmodule
`endif
`default_nettype wire

// File: rtl/ps2_key_decoder.sv
`default_nettype none
// ============================================================================
// Module   : ps2_key_decoder
// Brief    : PS/2 keyboard front end. Enables the keyboard (F4 / FA ack with
//            retry and timeout) then decodes set-2 make/break/extended codes
//            into held/press/release per configured key.
//            Optional typematic repeat: define PS2_KEY_REPEAT_EN.
// Revision : 1.0  initial release
// ============================================================================
module ps2_key_decoder
  import ps2_key_pkg::*;
#(
  parameter int                    NUM_KEYS      = 5,
  parameter logic [NUM_KEYS*9-1:0] KEY_CODES     = (NUM_KEYS*9)'(PS2_DEFAULT_KEY_CODES),
  parameter int                    ACK_TIMEOUT   = 2_000_000,
  parameter int                    MAX_RETRIES   = 3,
  parameter int                    REPEAT_DELAY  = 25_000_000,
  parameter int                    REPEAT_PERIOD = 5_000_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ps2_rx_en,
  input  logic                rx_valid,
  input  logic [7:0]          rx_data,
  input  logic                tx_done,
  output logic                tx_stb,
  output logic [7:0]          tx_data,
  output logic                init_done,
  output logic                init_err,
  output logic [NUM_KEYS-1:0] key_held,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release
);

  localparam int TW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
  localparam int RW = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);

  init_state_e         init_state_q, init_state_d;
  logic [RW-1:0]       retry_q, retry_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic                tx_stb_q, tx_stb_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                init_done_q, init_done_d;
  logic                init_err_q, init_err_d;

  dec_state_e          dec_state_q, dec_state_d;
  logic [NUM_KEYS-1:0] key_held_q, key_held_d;
  logic [NUM_KEYS-1:0] key_press_q, key_press_d;
  logic [NUM_KEYS-1:0] key_release_q, key_release_d;

  // Keyboard enable handshake: send F4, wait for FA, resend on error/timeout
  always_comb begin
    init_state_d = init_state_q;
    retry_d      = retry_q;
    timer_d      = '0;
    case (init_state_q)
      INIT_IDLE:    if (ps2_rx_en) init_state_d = INIT_SEND;
      INIT_SEND:    init_state_d = INIT_WAIT_TX;
      INIT_WAIT_TX: if (tx_done) init_state_d = INIT_WAIT_ACK;
      INIT_WAIT_ACK: begin
        timer_d = timer_q + 1'b1;
        if (rx_valid && (rx_data == PS2_ACK)) begin
          init_state_d = INIT_READY;
        end else if (rx_valid || (timer_q == TW'(ACK_TIMEOUT - 1))) begin
          if (retry_q < RW'(MAX_RETRIES)) begin
            retry_d      = retry_q + 1'b1;
            init_state_d = INIT_SEND;
          end else begin
            init_state_d = INIT_ERR;
          end
        end
      end
      default: ;
    endcase
    tx_stb_d    = (init_state_d == INIT_SEND);
    tx_data_d   = tx_stb_d ? PS2_CMD_ENABLE : tx_data_q;
    init_done_d = (init_state_d == INIT_READY);
    init_err_d  = (init_state_d == INIT_ERR);
  end

  logic       resolve;
  logic       is_break;
  logic [8:0] code;

  // Scan-code prefix tracking and per-key held/press/release update
  always_comb begin
    dec_state_d   = dec_state_q;
    key_held_d    = key_held_q;
    key_press_d   = '0;
    key_release_d = '0;
    resolve       = 1'b0;
    is_break      = 1'b0;
    code          = {1'b0, rx_data};
    if (init_done_q && rx_valid) begin
      case (dec_state_q)
        D_IDLE: begin
          if (rx_data == PS2_EXT)        dec_state_d = D_EXT;
          else if (rx_data == PS2_BREAK) dec_state_d = D_BRK;
          else if (!ps2_is_status(rx_data)) resolve = 1'b1;
        end
        D_EXT: begin
          if (rx_data == PS2_BREAK) begin
            dec_state_d = D_EXT_BRK;
          end else begin
            resolve     = 1'b1;
            code        = {1'b1, rx_data};
            dec_state_d = D_IDLE;
          end
        end
        D_BRK: begin
          resolve     = 1'b1;
          is_break    = 1'b1;
          dec_state_d = D_IDLE;
        end
        default: begin
          resolve     = 1'b1;
          is_break    = 1'b1;
          code        = {1'b1, rx_data};
          dec_state_d = D_IDLE;
        end
      endcase
    end
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (resolve && (code == KEY_CODES[9*i +: 9])) begin
        if (is_break) begin
          if (key_held_q[i]) begin
            key_held_d[i]    = 1'b0;
            key_release_d[i] = 1'b1;
          end
        end else if (!key_held_q[i]) begin
          key_held_d[i]  = 1'b1;
          key_press_d[i] = 1'b1;
        end
      end
    end
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      init_state_q  <= INIT_IDLE;
      retry_q       <= '0;
      timer_q       <= '0;
      tx_stb_q      <= 1'b0;
      tx_data_q     <= 8'h00;
      init_done_q   <= 1'b0;
      init_err_q    <= 1'b0;
      dec_state_q   <= D_IDLE;
      key_held_q    <= '0;
      key_press_q   <= '0;
      key_release_q <= '0;
    end else begin
      init_state_q  <= init_state_d;
      retry_q       <= retry_d;
      timer_q       <= timer_d;
      tx_stb_q      <= tx_stb_d;
      tx_data_q     <= tx_data_d;
      init_done_q   <= init_done_d;
      init_err_q    <= init_err_d;
      dec_state_q   <= dec_state_d;
      key_held_q    <= key_held_d;
      key_press_q   <= key_press_d;
      key_release_q <= key_release_d;
    end
  end

  assign tx_stb      = tx_stb_q;
  assign tx_data     = tx_data_q;
  assign init_done   = init_done_q;
  assign init_err    = init_err_q;
  assign key_held    = key_held_q;
  assign key_release = key_release_q;

`ifdef PS2_KEY_REPEAT_EN
  logic [NUM_KEYS-1:0] rep_tick;

  for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_repeat
    ps2_key_repeat #(
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_repeat (
      .clk         (clk),
      .rst         (rst),
      .held        (key_held_q[gi]),
      .make        (key_press_d[gi]),
      .repeat_tick (rep_tick[gi])
    );
  end : g_repeat

  assign key_press = key_press_q | rep_tick;
`else
  logic unused_repeat_params;
  assign unused_repeat_params = ^{REPEAT_DELAY[0], REPEAT_PERIOD[0]};
  assign key_press = key_press_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_key_decoder
// Brief    : Directed self-checking bench for ps2_key_decoder
//            (enable handshake, retries, timeout, decode, reset, repeat).
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ps2_key_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_rx_en = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       tx_done = 1'b0;
  logic       tx_stb;
  logic [7:0] tx_data;
  logic       init_done;
  logic       init_err;
  logic [4:0] key_held;
  logic [4:0] key_press;
  logic [4:0] key_release;

  int errors = 0;
  int checks = 0;
  int stb_count = 0;
  int bad_tx_data = 0;
  int base;

  always #5 clk = ~clk;

  ps2_key_decoder #(
    .NUM_KEYS      (5),
    .ACK_TIMEOUT   (40),
    .MAX_RETRIES   (3),
    .REPEAT_DELAY  (10),
    .REPEAT_PERIOD (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ps2_rx_en   (ps2_rx_en),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .tx_done     (tx_done),
    .tx_stb      (tx_stb),
    .tx_data     (tx_data),
    .init_done   (init_done),
    .init_err    (init_err),
    .key_held    (key_held),
    .key_press   (key_press),
    .key_release (key_release)
  );

  // Count host strobes mid-cycle and note any strobe without F4 on the bus
  always @(negedge clk) begin
    if (tx_stb) begin
      stb_count++;
      if (tx_data != 8'hF4) bad_tx_data++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_rx(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick(1);
    rx_valid = 1'b0;
  endtask

  task automatic pulse_tx_done();
    tx_done = 1'b1;
    tick(1);
    tx_done = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  // One F4 transmit followed by a keyboard reply byte
  task automatic handshake(input logic [7:0] reply);
    tick(4);
    pulse_tx_done();
    tick(2);
    send_rx(reply);
  endtask

  initial begin
    int exp_press;
    tick(2);
    // ---- reset state ----
    check("rst_tx_stb",  {31'b0, tx_stb}, 0);
    check("rst_tx_data", {24'b0, tx_data}, 32'h00);
    check("rst_done",    {31'b0, init_done}, 0);
    check("rst_err",     {31'b0, init_err}, 0);
    check("rst_held",    {27'b0, key_held}, 0);
    check("rst_press",   {27'b0, key_press}, 0);
    check("rst_release", {27'b0, key_release}, 0);
    rst = 1'b0;
    tick(1);

    // ---- basic enable: one F4, FA ack, done at rx cycle + 1 ----
    base = stb_count;
    ps2_rx_en = 1'b1;
    tick(4);
    check("t1_stb_cnt", stb_count - base, 1);
    check("t1_tx_data", {24'b0, tx_data}, 32'hF4);
    pulse_tx_done();
    tick(2);
    rx_valid = 1'b1;
    rx_data  = 8'hFA;
    check("t1_done_at_n", {31'b0, init_done}, 0);
    tick(1);
    rx_valid = 1'b0;
    check("t1_done_n1", {31'b0, init_done}, 1);
    check("t1_err",     {31'b0, init_err}, 0);
    tick(3);
    check("t1_stb_total", stb_count - base, 1);

    // ---- make / typematic make / break on extended key 0 ----
    send_rx(8'hE0); send_rx(8'h6B);
    check("t3_held",   {27'b0, key_held}, 5'b00001);
    check("t3_press",  {27'b0, key_press}, 5'b00001);
    tick(1);
    check("t3_press_1cyc", {27'b0, key_press}, 0);
    send_rx(8'hE0); send_rx(8'h6B);
    check("t3_typematic_press", {27'b0, key_press}, 0);
    check("t3_typematic_held",  {27'b0, key_held}, 5'b00001);
    send_rx(8'hE0); send_rx(8'hF0); send_rx(8'h6B);
    check("t3_brk_held",    {27'b0, key_held}, 0);
    check("t3_brk_release", {27'b0, key_release}, 5'b00001);
    tick(1);
    check("t3_release_1cyc", {27'b0, key_release}, 0);
    send_rx(8'hE0); send_rx(8'hF0); send_rx(8'h6B);
    check("t3_unheld_brk", {27'b0, key_release}, 0);

    // ---- rollover, non-extended mismatch, status byte ----
    send_rx(8'h29);
    check("t4_drop", {27'b0, key_held}, 5'b10000);
    send_rx(8'hE0); send_rx(8'h74);
    check("t4_roll", {27'b0, key_held}, 5'b10010);
    send_rx(8'hF0); send_rx(8'h29);
    check("t4_brk_drop", {27'b0, key_held}, 5'b00010);
    check("t4_rel_drop", {27'b0, key_release}, 5'b10000);
    send_rx(8'h6B);
    check("t4_nonext_held",  {27'b0, key_held}, 5'b00010);
    check("t4_nonext_press", {27'b0, key_press}, 0);
    send_rx(8'hAA);
    send_rx(8'hE0); send_rx(8'hF0); send_rx(8'h74);
    check("t4_status_ign", {27'b0, key_held}, 0);
    check("t4_rel_right",  {27'b0, key_release}, 5'b00010);

    // ---- reset between E0 and F0 ----
    send_rx(8'hE0); send_rx(8'h75);
    check("t5_rotate", {27'b0, key_held}, 5'b00100);
    send_rx(8'hE0);
    do_reset();
    check("t5_held_clr", {27'b0, key_held}, 0);
    check("t5_done_clr", {31'b0, init_done}, 0);
    base = stb_count;
    tick(4);
    check("t5_restart_stb", stb_count - base, 1);
    send_rx(8'hE0); send_rx(8'h75);
    check("t5_ignored", {27'b0, key_held}, 0);
    pulse_tx_done();
    tick(2);
    send_rx(8'hFA);
    check("t5_done", {31'b0, init_done}, 1);
    send_rx(8'hE0); send_rx(8'h75);
    check("t5_fresh_prefix", {27'b0, key_press}, 5'b00100);
    send_rx(8'hE0); send_rx(8'hF0); send_rx(8'h75);
    check("t5_rel", {27'b0, key_release}, 5'b00100);

    // ---- three resends then ack ----
    do_reset();
    base = stb_count;
    for (int i = 0; i < 3; i++) handshake(8'hFE);
    handshake(8'hFA);
    check("t2_stb4", stb_count - base, 4);
    check("t2_done", {31'b0, init_done}, 1);
    check("t2_err",  {31'b0, init_err}, 0);

    // ---- retries exhausted ----
    do_reset();
    base = stb_count;
    for (int i = 0; i < 4; i++) handshake(8'hFE);
    tick(10);
    check("t2e_err",  {31'b0, init_err}, 1);
    check("t2e_done", {31'b0, init_done}, 0);
    check("t2e_stb4", stb_count - base, 4);
    send_rx(8'hFA);
    tick(5);
    check("t2e_sticky", {31'b0, init_err}, 1);

    // ---- ack timeout triggers one resend ----
    do_reset();
    base = stb_count;
    tick(4);
    pulse_tx_done();
    tick(45);
    check("tto_resend", stb_count - base, 2);
    check("tto_done0",  {31'b0, init_done}, 0);
    pulse_tx_done();
    tick(2);
    send_rx(8'hFA);
    check("tto_done", {31'b0, init_done}, 1);

    // ---- press timing while held ----
    send_rx(8'h29);
    check("t6_rel1", {31'b0, key_press[4]}, 1);
    for (int rel = 2; rel <= 22; rel++) begin
      tick(1);
`ifdef PS2_KEY_REPEAT_EN
      exp_press = (rel == 11 || rel == 15 || rel == 19) ? 1 : 0;
`else
      exp_press = 0;
`endif
      check($sformatf("t6_rel%0d", rel), {31'b0, key_press[4]}, exp_press);
    end
    check("t6_held", {27'b0, key_held}, 5'b10000);
    send_rx(8'hF0); send_rx(8'h29);
    check("t6_release", {27'b0, key_release}, 5'b10000);

    check("tx_data_on_stb", bad_tx_data, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
